lock_auto_operator: RTL and testbench

LOCK_AUTO_OPERATOR -- requirements
Module: lock_auto_operator

---
 rtl/lock_auto_operator.sv | 178 +++++++++++++++++
 tb/tb_lock_auto_operator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_auto_operator.sv
// lock_auto_operator: sequences a gondola through a water lock.
// It handles arrival, water adjust, the door pulses and departure.
// Every output is registered. Edges on the arrival switches are taken
// against a one-cycle-delayed copy of each switch.
module lock_auto_operator #(
  parameter int unsigned ARR_DELAY  = 300,
  parameter int unsigned DEPT_DELAY = 300,
  parameter int unsigned PULSE_GAP  = 4,
  parameter int unsigned MAX_PULSES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       arrive_outer,
  input  logic       arrive_inner,
  input  logic       outer_openable,
  input  logic       inner_openable,
  output logic       inc_water_level,
  output logic       dec_water_level,
  output logic       outer_door_open,
  output logic       inner_door_open,
  output logic [2:0] state,
  output logic       busy,
  output logic       to_inner,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARRIVING  = 3'd1,
    TRANSFER  = 3'd2,
    DEPARTING = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int unsigned TIMER_MAX = (ARR_DELAY > DEPT_DELAY) ? ARR_DELAY : DEPT_DELAY;
  localparam int unsigned GW        = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam int unsigned PW        = $clog2(MAX_PULSES + 1);

  localparam logic [15:0]   TIMER_SAT = 16'(TIMER_MAX);
  localparam logic [15:0]   ARR_T     = 16'(ARR_DELAY);
  localparam logic [15:0]   DEPT_T    = 16'(DEPT_DELAY);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(PULSE_GAP - 1);
  localparam logic [PW-1:0] PMAX      = PW'(MAX_PULSES);

  state_t        state_q, state_d;
  logic          to_inner_q, to_inner_d;
  logic [15:0]   timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          arrive_outer_q, arrive_inner_q;
  logic          inc_d, dec_d, outer_door_d, inner_door_d;

  logic          edge_outer, edge_inner;
  logic          adjusting, target_outer, target_open;
  logic          can_pulse, exhausted, door_fire;

  assign edge_outer = arrive_outer & ~arrive_outer_q;
  assign edge_inner = arrive_inner & ~arrive_inner_q;

  // ARRIVING aims for the arrival side and TRANSFER aims for the
  // departure side. The arrival side is the outer side when to_inner=1.
  assign adjusting    = (state_q == ARRIVING) || (state_q == TRANSFER);
  assign target_outer = (state_q == ARRIVING) ? to_inner_q : ~to_inner_q;
  assign target_open  = target_outer ? outer_openable : inner_openable;
  assign can_pulse    = adjusting && !target_open && (gap_q == '0) && (pcnt_q < PMAX);
  assign exhausted    = adjusting && !target_open && (gap_q == '0) && (pcnt_q >= PMAX);

  // State register and registered outputs. Reset has priority over all
  // other inputs. The edge-detect copies load the live switch level even
  // during reset, so a switch held high through reset gives no edge.
  always_ff @(posedge clk) begin
    arrive_outer_q <= arrive_outer;
    arrive_inner_q <= arrive_inner;
    if (reset) begin
      state_q         <= IDLE;
      to_inner_q      <= 1'b0;
      timer_q         <= '0;
      gap_q           <= '0;
      pcnt_q          <= '0;
      inc_water_level <= 1'b0;
      dec_water_level <= 1'b0;
      outer_door_open <= 1'b0;
      inner_door_open <= 1'b0;
      busy            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q         <= state_d;
      to_inner_q      <= to_inner_d;
      timer_q         <= timer_d;
      gap_q           <= gap_d;
      pcnt_q          <= pcnt_d;
      inc_water_level <= inc_d;
      dec_water_level <= dec_d;
      outer_door_open <= outer_door_d;
      inner_door_open <= inner_door_d;
      busy            <= (state_d != IDLE);
      fault           <= (state_d == FAULT);
    end
  end

  // Next-state and direction selection
  always_comb begin
    state_d    = state_q;
    to_inner_d = to_inner_q;
    case (state_q)
      IDLE: begin
        if (edge_outer) begin
          state_d    = ARRIVING;
          to_inner_d = 1'b1;
        end else if (edge_inner) begin
          state_d    = ARRIVING;
          to_inner_d = 1'b0;
        end
      end
      ARRIVING: begin
        if (exhausted)
          state_d = FAULT;
        else if (target_open && (timer_q >= ARR_T))
          state_d = TRANSFER;
      end
      TRANSFER: begin
        if (exhausted)
          state_d = FAULT;
        else if (target_open)
          state_d = DEPARTING;
      end
      DEPARTING: begin
        if (timer_q >= DEPT_T) begin
          state_d    = IDLE;
          to_inner_d = 1'b0;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Pulse generation, the tick timer and the water-adjust counters.
  // Each door pulse belongs to the transition that leaves an adjust phase,
  // and it opens the door on the side that phase was adjusting toward.
  always_comb begin
    inc_d        = 1'b0;
    dec_d        = 1'b0;
    outer_door_d = 1'b0;
    inner_door_d = 1'b0;
    timer_d      = (tick && (timer_q < TIMER_SAT)) ? timer_q + 16'd1 : timer_q;
    gap_d        = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    pcnt_d       = pcnt_q;

    if (can_pulse) begin
      inc_d  = ~target_outer;
      dec_d  = target_outer;
      pcnt_d = pcnt_q + PW'(1);
      gap_d  = GAP_LOAD;
    end

    door_fire = ((state_q == ARRIVING) && (state_d == TRANSFER)) ||
                ((state_q == TRANSFER) && (state_d == DEPARTING));
    if (door_fire) begin
      outer_door_d = target_outer;
      inner_door_d = ~target_outer;
    end

    if (state_d != state_q) begin
      if ((state_d == ARRIVING) || (state_d == DEPARTING))
        timer_d = '0;
      if ((state_d == ARRIVING) || (state_d == TRANSFER)) begin
        gap_d  = '0;
        pcnt_d = '0;
      end
    end
  end

  assign state    = state_q;
  assign to_inner = to_inner_q;

endmodule

// File: tb/tb_lock_auto_operator.sv
// Testbench for lock_auto_operator (ARR_DELAY=3, DEPT_DELAY=2, PULSE_GAP=2,
// MAX_PULSES=4, tick every cycle). Every cycle pushes an expected output
// vector to a queue. The vector comes from a hand-filled table or from a
// behavioural lock model. It is popped and compared after the clock edge.
module tb_lock_auto_operator;

  logic       clk = 1'b0;
  logic       reset_s, tick_s, ao_s, ai_s, oo_s, io_s;
  logic       inc_w, dec_w, od_w, id_w, busy_w, ti_w, fault_w;
  logic [2:0] state_w;

  lock_auto_operator #(
    .ARR_DELAY (3),
    .DEPT_DELAY(2),
    .PULSE_GAP (2),
    .MAX_PULSES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset_s),
    .tick           (tick_s),
    .arrive_outer   (ao_s),
    .arrive_inner   (ai_s),
    .outer_openable (oo_s),
    .inner_openable (io_s),
    .inc_water_level(inc_w),
    .dec_water_level(dec_w),
    .outer_door_open(od_w),
    .inner_door_open(id_w),
    .state          (state_w),
    .busy           (busy_w),
    .to_inner       (ti_w),
    .fault          (fault_w)
  );

  always #5 clk = ~clk;

  // The vector is {state[2:0], busy, to_inner, fault, inc, dec, outer_door, inner_door}.
  logic [9:0] exp_q[$];
  logic [9:0] last;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model state
  int m_st = 0, m_timer = 0, m_gap = 0, m_pc = 0;
  bit m_ti = 0, m_ao = 0, m_ai = 0;

  typedef struct {
    logic rst, ao, ai, oo, io;
    logic [2:0] st;
    logic busy, ti, flt, inc, dec, od, id;
  } vec_t;
  vec_t tbl[13];

  task automatic model_step(output logic [9:0] e);
    bit eo, ei, inc, dec, od, id, side_outer, open;
    int tnext;
    inc = 0; dec = 0; od = 0; id = 0;
    if (reset_s) begin
      m_st = 0; m_ti = 0; m_timer = 0; m_gap = 0; m_pc = 0;
      m_ao = ao_s; m_ai = ai_s;
    end else begin
      eo = ao_s && !m_ao;
      ei = ai_s && !m_ai;
      m_ao = ao_s; m_ai = ai_s;
      tnext = (m_timer < 3) ? m_timer + 1 : 3;
      case (m_st)
        0: begin
          m_timer = tnext;
          if (eo || ei) begin
            m_st = 1; m_ti = eo; m_timer = 0; m_gap = 0; m_pc = 0;
          end
        end
        1, 2: begin
          side_outer = (m_st == 1) ? m_ti : !m_ti;
          open = side_outer ? oo_s : io_s;
          if (open) begin
            if (m_st == 1 && m_timer >= 3) begin
              if (side_outer) od = 1; else id = 1;
              m_st = 2; m_gap = 0; m_pc = 0; m_timer = tnext;
            end else if (m_st == 2) begin
              if (side_outer) od = 1; else id = 1;
              m_st = 3; m_timer = 0;
            end else begin
              m_timer = tnext;
              if (m_gap > 0) m_gap--;
            end
          end else begin
            m_timer = tnext;
            if (m_gap > 0) m_gap--;
            else if (m_pc < 4) begin
              if (side_outer) dec = 1; else inc = 1;
              m_pc++; m_gap = 1;
            end else m_st = 4;
          end
        end
        3: begin
          if (m_timer >= 2) begin m_st = 0; m_ti = 0; end
          m_timer = tnext;
        end
        default: m_timer = tnext;
      endcase
    end
    e = {3'(m_st), m_st != 0, m_ti, m_st == 4, inc, dec, od, id};
  endtask

  task automatic cycle(input bit use_tbl, input logic [9:0] texp, input string tag);
    logic [9:0] me, ev;
    model_step(me);
    exp_q.push_back(use_tbl ? texp : me);
    @(posedge clk);
    #1;
    ev = exp_q.pop_front();
    last = {state_w, busy_w, ti_w, fault_w, inc_w, dec_w, od_w, id_w};
    n_cmp++;
    if (last !== ev) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, last, ev);
    end
  endtask

  task automatic step(input string tag);
    cycle(1'b0, '0, tag);
  endtask

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndec, npulse;
    bit hit;
    tbl[0]  = '{1,0,0,1,0, 0,0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,0,1,0, 1,1,1,0,0,0,0,0};
    tbl[2]  = '{0,1,0,1,0, 1,1,1,0,0,0,0,0};
    tbl[3]  = '{0,1,0,1,0, 1,1,1,0,0,0,0,0};
    tbl[4]  = '{0,1,0,1,0, 1,1,1,0,0,0,0,0};
    tbl[5]  = '{0,1,0,1,0, 2,1,1,0,0,0,1,0};
    tbl[6]  = '{0,1,0,1,0, 2,1,1,0,1,0,0,0};
    tbl[7]  = '{0,1,0,1,0, 2,1,1,0,0,0,0,0};
    tbl[8]  = '{0,1,0,1,0, 2,1,1,0,1,0,0,0};
    tbl[9]  = '{0,1,0,1,1, 3,1,1,0,0,0,0,1};
    tbl[10] = '{0,1,0,1,1, 3,1,1,0,0,0,0,0};
    tbl[11] = '{0,1,0,1,1, 3,1,1,0,0,0,0,0};
    tbl[12] = '{0,1,0,1,1, 0,0,0,0,0,0,0,0};

    tick_s = 1; reset_s = 1; ao_s = 1; ai_s = 0; oo_s = 1; io_s = 0;

    // Reset with arrive_outer held high: no edge after release
    step("rst_hold0");
    step("rst_hold1");
    reset_s = 0;
    step("release_hold0");
    step("release_hold1");
    check("held_switch_no_start", int'(last[9:7]), 0);

    // Full outer->inner run from the table
    for (int i = 0; i < 13; i++) begin
      reset_s = tbl[i].rst; ao_s = tbl[i].ao; ai_s = tbl[i].ai;
      oo_s = tbl[i].oo; io_s = tbl[i].io;
      cycle(1'b1, {tbl[i].st, tbl[i].busy, tbl[i].ti, tbl[i].flt,
                   tbl[i].inc, tbl[i].dec, tbl[i].od, tbl[i].id}, $sformatf("tbl%0d", i));
    end

    // inner->outer: inc pulses at entry+1, +3, +5, then the inner door
    reset_s = 1; ao_s = 0; ai_s = 0; oo_s = 0; io_s = 0;
    step("r41_rst");
    reset_s = 0; ai_s = 1;
    step("r41_entry");
    check("r41_to_inner", int'(last[5]), 0);
    for (int k = 1; k <= 6; k++) begin
      step($sformatf("r41_adj%0d", k));
      check($sformatf("r41_inc_at_%0d", k), int'(last[3]), k % 2);
    end
    io_s = 1;
    step("r41_open");
    check("r41_inner_door", int'(last[0]), 1);
    step("r41_xfer0");
    step("r41_xfer1");
    oo_s = 1;
    step("r41_depart");
    check("r41_outer_door", int'(last[1]), 1);
    hit = 0;
    for (int k = 0; k < 6 && !hit; k++) begin
      step("r41_drain");
      if (last[9:7] == 3'd0) hit = 1;
    end
    check("r41_back_idle", int'(hit), 1);

    // Openable never asserted: four dec pulses then FAULT
    reset_s = 1; ai_s = 0; ao_s = 0; oo_s = 0; io_s = 0;
    step("r42_rst");
    reset_s = 0; ao_s = 1;
    step("r42_entry");
    ndec = 0; hit = 0;
    for (int k = 0; k < 12 && !hit; k++) begin
      step("r42_adj");
      if (last[2]) ndec++;
      if (last[9:7] == 3'd4) hit = 1;
    end
    check("r42_pulse_count", ndec, 4);
    check("r42_fault_flag", int'(last[4]), 1);
    ao_s = 0;
    step("r42_ign0");
    ao_s = 1; ai_s = 1;
    step("r42_ign1");
    check("r42_edges_ignored", int'(last[9:7]), 4);
    reset_s = 1;
    step("r42_reset");
    check("r42_reset_clears", int'(last[9:7]), 0);
    reset_s = 0; ao_s = 0; ai_s = 0;
    step("r42_after");

    // Simultaneous edges: outer wins; an inner edge in TRANSFER is ignored
    reset_s = 1; oo_s = 1; io_s = 0;
    step("r43_rst");
    reset_s = 0; ao_s = 1; ai_s = 1;
    step("r43_both");
    check("r43_outer_wins", int'(last[5]), 1);
    hit = 0;
    for (int k = 0; k < 8 && !hit; k++) begin
      step("r43_arr");
      if (last[9:7] == 3'd2) hit = 1;
    end
    check("r43_reach_transfer", int'(hit), 1);
    ai_s = 0;
    step("r43_ai_low");
    ai_s = 1;
    step("r43_ai_edge");
    check("r43_transfer_kept", int'(last[9:7]), 2);
    io_s = 1;
    step("r43_depart");
    for (int k = 0; k < 4; k++) step("r43_drain");
    check("r43_idle", int'(last[9:7]), 0);

    // Reset in TRANSFER between pulses
    reset_s = 1; ao_s = 0; ai_s = 0; oo_s = 1; io_s = 0;
    step("r44_rst");
    reset_s = 0; ao_s = 1;
    step("r44_entry");
    hit = 0;
    for (int k = 0; k < 12 && !hit; k++) begin
      step("r44_run");
      if (last[3]) hit = 1;
    end
    check("r44_first_pulse", int'(hit), 1);
    reset_s = 1;
    step("r44_mid_reset");
    check("r44_state_idle", int'(last[9:7]), 0);
    reset_s = 0;
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      step("r44_quiet");
      if (last[3] || last[2]) npulse++;
    end
    check("r44_no_pulses", npulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
